// File: rtl/tlc_pkt_pkg.sv
// tlc_pkt_pkg: shared state encoding, fifo_data field positions and counter width
package tlc_pkt_pkg;
   localparam int CNT_W = 16;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PASS = 2'd1, ST_DROP = 2'd2} state_e;
   function automatic int bit_eop(input int dw);
      return dw;
   endfunction
   function automatic int bit_trunc(input int dw);
      return dw + 1;
   endfunction
endpackage

// File: rtl/tlc_pkt_wr_ctrl_if.sv
// tlc_pkt_wr_ctrl_if: framed input stream, FIFO write side and statistics
interface tlc_pkt_wr_ctrl_if #(parameter int c_DATA_WIDTH = 64);
   import tlc_pkt_pkg::*;
   logic                    in_valid;
   logic                    in_sop;
   logic                    in_eop;
   logic [c_DATA_WIDTH-1:0] in_data;
   logic                    fifo_afull;
   logic                    fifo_wr_en;
   logic                    fifo_wr_eop;
   logic [c_DATA_WIDTH+1:0] fifo_data;
   logic                    pkt_err;
   logic [CNT_W-1:0]        drop_cnt;
   logic [CNT_W-1:0]        trunc_cnt;
   modport master (
      output in_valid, in_sop, in_eop, in_data, fifo_afull,
      input  fifo_wr_en, fifo_wr_eop, fifo_data, pkt_err, drop_cnt, trunc_cnt
   );
   modport slave (
      input  in_valid, in_sop, in_eop, in_data, fifo_afull,
      output fifo_wr_en, fifo_wr_eop, fifo_data, pkt_err, drop_cnt, trunc_cnt
   );
endinterface

// File: rtl/tlc_sat_cnt.sv
// tlc_sat_cnt: saturating incrementer with async active-low reset
module tlc_sat_cnt #(parameter int W = 16) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/tlc_pkt_wr_ctrl.sv
// tlc_pkt_wr_ctrl: admits, truncates or drops framed packets ahead of the async packet FIFO
module tlc_pkt_wr_ctrl
   import tlc_pkt_pkg::*;
#(
   parameter int c_DATA_WIDTH    = 64,
   parameter int c_MAX_PKT_WORDS = 128,
   parameter int c_LEN_WIDTH     = 8
) (
   input logic                 clk,
   input logic                 rstn,
   tlc_pkt_wr_ctrl_if.slave    bus
);
   localparam int BIT_EOP   = bit_eop(c_DATA_WIDTH);
   localparam int BIT_TRUNC = bit_trunc(c_DATA_WIDTH);
   localparam logic [c_LEN_WIDTH-1:0] MAX_LEN = c_LEN_WIDTH'(c_MAX_PKT_WORDS);
   state_e                  state_q, state_d;
   logic [c_LEN_WIDTH-1:0]  len_q, len_d, len_inc;
   logic                    wr_en_q, wr_en_d;
   logic                    wr_eop_q, wr_eop_d;
   logic                    err_q, err_d;
   logic [c_DATA_WIDTH+1:0] data_q, data_d;
   logic                    eop_f, trunc_f, admit, drop_inc, trunc_inc;
   assign len_inc = (state_q == ST_IDLE) ? c_LEN_WIDTH'(1) : len_q + 1'b1;
   assign admit   = bus.in_valid && ((state_q == ST_IDLE && bus.in_sop && !bus.fifo_afull) ||
                                     (state_q == ST_PASS && !bus.in_sop));
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wr_en_d   = 1'b0;
      wr_eop_d  = 1'b0;
      err_d     = 1'b0;
      eop_f     = 1'b0;
      trunc_f   = 1'b0;
      drop_inc  = 1'b0;
      trunc_inc = 1'b0;
      if (admit) begin
         wr_en_d = 1'b1;
         len_d   = len_inc;
         if (bus.in_eop) begin
            eop_f    = 1'b1;
            wr_eop_d = 1'b1;
            state_d  = ST_IDLE;
         end else if (len_inc == MAX_LEN) begin
            eop_f     = 1'b1;
            trunc_f   = 1'b1;
            wr_eop_d  = 1'b1;
            err_d     = 1'b1;
            trunc_inc = 1'b1;
            state_d   = ST_DROP;
         end else
            state_d = ST_PASS;
      end else if (bus.in_valid) begin
         // sop outside DROP that was not admitted: afull at admission, or a stray sop that closes the open packet
         if (bus.in_sop && state_q != ST_DROP) begin
            drop_inc = 1'b1;
            wr_eop_d = (state_q == ST_PASS);
            err_d    = (state_q == ST_PASS);
            state_d  = bus.in_eop ? ST_IDLE : ST_DROP;
         end else if (state_q == ST_IDLE)
            err_d = 1'b1;
         else if (bus.in_eop)
            state_d = ST_IDLE;
      end
      data_d = '0;
      if (wr_en_d) begin
         data_d[c_DATA_WIDTH-1:0] = bus.in_data;
         data_d[BIT_EOP]          = eop_f;
         data_d[BIT_TRUNC]        = trunc_f;
      end
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         wr_en_q  <= 1'b0;
         wr_eop_q <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         wr_en_q  <= wr_en_d;
         wr_eop_q <= wr_eop_d;
         err_q    <= err_d;
         data_q   <= data_d;
      end
   tlc_sat_cnt #(.W(CNT_W)) u_drop_cnt  (.clk(clk), .rstn(rstn), .inc(drop_inc),  .cnt(bus.drop_cnt));
   tlc_sat_cnt #(.W(CNT_W)) u_trunc_cnt (.clk(clk), .rstn(rstn), .inc(trunc_inc), .cnt(bus.trunc_cnt));
   assign bus.fifo_wr_en  = wr_en_q;
   assign bus.fifo_wr_eop = wr_eop_q;
   assign bus.fifo_data   = data_q;
   assign bus.pkt_err     = err_q;
endmodule

// File: tb/tb_tlc_pkt_wr_ctrl.sv
// tb_tlc_pkt_wr_ctrl: table-driven vectors plus truncation, reset and saturation sequences
module tb_tlc_pkt_wr_ctrl;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   tlc_pkt_wr_ctrl_if #(.c_DATA_WIDTH(64)) bus ();
   tlc_pkt_wr_ctrl #(.c_DATA_WIDTH(64), .c_MAX_PKT_WORDS(128), .c_LEN_WIDTH(8)) dut (
      .clk(clk), .rstn(rstn), .bus(bus)
   );
   typedef struct packed {
      logic        v, s, e, af;
      logic [63:0] d;
      logic        wr, weop, feop, tr, err;
      logic [15:0] dc, tc;
   } vec_t;
   vec_t vec [24];
   task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask
   task automatic step(input logic v, input logic s, input logic e, input logic af, input logic [63:0] d);
      @(negedge clk);
      bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.fifo_afull = af; bus.in_data = d;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int wr_n, err_n;
      //          v  s  e af  data      wr weop feop tr err  dc  tc
      vec[0]  = '{1, 1, 0, 0, 64'hA0,   1, 0, 0, 0, 0, 16'd0, 16'd0};
      vec[1]  = '{1, 0, 0, 0, 64'hA1,   1, 0, 0, 0, 0, 16'd0, 16'd0};
      vec[2]  = '{1, 0, 0, 0, 64'hA2,   1, 0, 0, 0, 0, 16'd0, 16'd0};
      vec[3]  = '{1, 0, 1, 0, 64'hA3,   1, 1, 1, 0, 0, 16'd0, 16'd0};
      vec[4]  = '{0, 0, 0, 0, 64'h00,   0, 0, 0, 0, 0, 16'd0, 16'd0};
      vec[5]  = '{1, 1, 1, 0, 64'h55,   1, 1, 1, 0, 0, 16'd0, 16'd0};
      vec[6]  = '{1, 1, 1, 1, 64'h55,   0, 0, 0, 0, 0, 16'd1, 16'd0};
      vec[7]  = '{1, 0, 0, 0, 64'h77,   0, 0, 0, 0, 1, 16'd1, 16'd0};
      vec[8]  = '{1, 1, 0, 0, 64'hB0,   1, 0, 0, 0, 0, 16'd1, 16'd0};
      vec[9]  = '{1, 0, 0, 0, 64'hB1,   1, 0, 0, 0, 0, 16'd1, 16'd0};
      vec[10] = '{1, 0, 0, 0, 64'hB2,   1, 0, 0, 0, 0, 16'd1, 16'd0};
      vec[11] = '{1, 1, 0, 0, 64'hC0,   0, 1, 0, 0, 1, 16'd2, 16'd0};
      vec[12] = '{1, 0, 0, 0, 64'hC1,   0, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[13] = '{1, 1, 0, 0, 64'hC2,   0, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[14] = '{1, 0, 1, 0, 64'hC3,   0, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[15] = '{1, 1, 0, 0, 64'hD0,   1, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[16] = '{0, 0, 0, 0, 64'h00,   0, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[17] = '{1, 0, 0, 1, 64'hD1,   1, 0, 0, 0, 0, 16'd2, 16'd0};
      vec[18] = '{1, 0, 1, 1, 64'hD2,   1, 1, 1, 0, 0, 16'd2, 16'd0};
      vec[19] = '{1, 1, 0, 1, 64'hE0,   0, 0, 0, 0, 0, 16'd3, 16'd0};
      vec[20] = '{1, 0, 1, 0, 64'hE1,   0, 0, 0, 0, 0, 16'd3, 16'd0};
      vec[21] = '{1, 1, 0, 0, 64'hF0,   1, 0, 0, 0, 0, 16'd3, 16'd0};
      vec[22] = '{1, 1, 1, 0, 64'h60,   0, 1, 0, 0, 1, 16'd4, 16'd0};
      vec[23] = '{1, 1, 1, 0, 64'h61,   1, 1, 1, 0, 0, 16'd4, 16'd0};
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.fifo_afull = 1'b0; bus.in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst wr_en",     66'(bus.fifo_wr_en),  66'd0);
      chk("rst wr_eop",    66'(bus.fifo_wr_eop), 66'd0);
      chk("rst pkt_err",   66'(bus.pkt_err),     66'd0);
      chk("rst drop_cnt",  66'(bus.drop_cnt),    66'd0);
      chk("rst trunc_cnt", 66'(bus.trunc_cnt),   66'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step(vec[i].v, vec[i].s, vec[i].e, vec[i].af, vec[i].d);
         chk($sformatf("v%0d wr_en", i),     66'(bus.fifo_wr_en),  66'(vec[i].wr));
         chk($sformatf("v%0d wr_eop", i),    66'(bus.fifo_wr_eop), 66'(vec[i].weop));
         chk($sformatf("v%0d pkt_err", i),   66'(bus.pkt_err),     66'(vec[i].err));
         chk($sformatf("v%0d drop_cnt", i),  66'(bus.drop_cnt),    66'(vec[i].dc));
         chk($sformatf("v%0d trunc_cnt", i), 66'(bus.trunc_cnt),   66'(vec[i].tc));
         if (vec[i].wr)
            chk($sformatf("v%0d fifo_data", i), bus.fifo_data, {vec[i].tr, vec[i].feop, vec[i].d});
      end
      wr_n = 0; err_n = 0;
      for (int k = 0; k < 130; k++) begin
         step(1'b1, k == 0, k == 129, 1'b0, 64'(k));
         if (bus.fifo_wr_en) wr_n++;
         if (bus.pkt_err) err_n++;
         if (k == 126) chk("trunc w127 wr_eop", 66'(bus.fifo_wr_eop), 66'd0);
         if (k == 127) begin
            chk("trunc w128 wr_eop", 66'(bus.fifo_wr_eop), 66'd1);
            chk("trunc w128 data", bus.fifo_data, {2'b11, 64'd127});
         end
      end
      chk("trunc writes",    66'(wr_n),          66'd128);
      chk("trunc errs",      66'(err_n),         66'd1);
      chk("trunc trunc_cnt", 66'(bus.trunc_cnt), 66'd1);
      chk("trunc drop_cnt",  66'(bus.drop_cnt),  66'd4);
      step(1'b1, 1'b1, 1'b1, 1'b0, 64'h33);
      chk("post trunc wr_en", 66'(bus.fifo_wr_en), 66'd1);
      chk("post trunc data",  bus.fifo_data,       {2'b01, 64'h33});
      step(1'b1, 1'b1, 1'b0, 1'b0, 64'h90);
      step(1'b1, 1'b0, 1'b0, 1'b0, 64'h91);
      chk("pre rst wr_en", 66'(bus.fifo_wr_en), 66'd1);
      rstn = 1'b0;
      #1;
      chk("mid rst wr_en",     66'(bus.fifo_wr_en),  66'd0);
      chk("mid rst data",      bus.fifo_data,        66'd0);
      chk("mid rst trunc_cnt", 66'(bus.trunc_cnt),   66'd0);
      chk("mid rst drop_cnt",  66'(bus.drop_cnt),    66'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0, 64'h99);
      chk("post rst wr_en",  66'(bus.fifo_wr_en),  66'd1);
      chk("post rst wr_eop", 66'(bus.fifo_wr_eop), 66'd1);
      chk("post rst data",   bus.fifo_data,        {2'b01, 64'h99});
      step(1'b1, 1'b0, 1'b0, 1'b0, 64'h9A);
      chk("post rst orphan err", 66'(bus.pkt_err),    66'd1);
      chk("post rst orphan wr",  66'(bus.fifo_wr_en), 66'd0);
      for (int k = 0; k < 65534; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
      chk("sat drop 65534", 66'(bus.drop_cnt), 66'hFFFE);
      repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
      chk("sat drop 65537", 66'(bus.drop_cnt), 66'hFFFF);
      chk("sat wr_en",      66'(bus.fifo_wr_en), 66'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
